// File: rtl/pred_pkg.sv
// pred_pkg: shared types and default sizing for the pred_mc edge-delay block.
// Optional build macro PRED_SYNC_EN (see pred_mc) does not affect this file.
package pred_pkg;

    // Default channel count and delay width used by the module parameters.
    localparam int PRED_CHANNELS_DEF = 2;
    localparam int PRED_DELAY_W_DEF  = 8;

    // Delay value at the default width (handy for benches and integrators).
    typedef logic [PRED_DELAY_W_DEF-1:0] pred_delay_t;

    // Per-channel control state: IDLE waits for a mismatch, COUNT times it out.
    typedef enum logic {
        PRED_IDLE  = 1'b0,
        PRED_COUNT = 1'b1
    } pred_state_e;

endpackage

// File: rtl/pred_if.sv
// pred_if: signal bundle between the phase-detect logic (master) and the
// multi-channel edge-delay block (slave).
interface pred_if #(
    parameter int CHANNELS = 2,
    parameter int DELAY_W  = 8
);
    logic [CHANNELS-1:0] sgn;
    logic [DELAY_W-1:0]  shift_rise;
    logic [DELAY_W-1:0]  shift_fall;
    logic                mode;
    logic [CHANNELS-1:0] sgn_pre;
    logic [CHANNELS-1:0] busy;

    modport master (
        output sgn, shift_rise, shift_fall, mode,
        input  sgn_pre, busy
    );

    modport slave (
        input  sgn, shift_rise, shift_fall, mode,
        output sgn_pre, busy
    );
endinterface

// File: rtl/pred_chan.sv
// pred_chan: one edge-delay channel. A mismatch between the input and the
// registered output starts a count of S cycles (S latched at detection from
// shift_rise or shift_fall); the output takes the input value when the count
// expires. If the input reverts mid-count, mode selects inertial abort (0)
// or a frozen count that resumes when the mismatch returns (1).
module pred_chan
    import pred_pkg::*;
#(
    parameter int DELAY_W = PRED_DELAY_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sgn,
    input  logic [DELAY_W-1:0] shift_rise,
    input  logic [DELAY_W-1:0] shift_fall,
    input  logic               mode,
    output logic               sgn_pre,
    output logic               busy
);

    pred_state_e        state;
    logic [DELAY_W-1:0] cnt;
    logic [DELAY_W-1:0] shift_sel;
    logic               mismatch;

    // A pending transition exists whenever input and output disagree.
    assign mismatch  = sgn ^ sgn_pre;
    // The target level decides which delay applies to this edge.
    assign shift_sel = sgn ? shift_rise : shift_fall;

    // Channel FSM with counter, output register and registered busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= PRED_IDLE;
            cnt     <= '0;
            sgn_pre <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                PRED_IDLE: begin
                    if (mismatch) begin
                        if (shift_sel == '0) begin
                            sgn_pre <= sgn;
                        end else begin
                            // Count of S-1 makes the output change at edge n+S.
                            cnt   <= shift_sel - DELAY_W'(1);
                            state <= PRED_COUNT;
                            busy  <= 1'b1;
                        end
                    end
                end
                PRED_COUNT: begin
                    if (mismatch) begin
                        if (cnt == '0) begin
                            sgn_pre <= sgn;
                            state   <= PRED_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            cnt <= cnt - DELAY_W'(1);
                        end
                    end else if (!mode) begin
                        // Inertial: a reverted input swallows the pulse.
                        state <= PRED_IDLE;
                        busy  <= 1'b0;
                    end
                    // Hold: stay in COUNT with cnt frozen until mismatch returns.
                end
                default: begin
                    state <= PRED_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pred_mc.sv
// pred_mc: multi-channel programmable edge-delay (dead-time / phase-shift)
// block. Optional build macro PRED_SYNC_EN inserts a 2-flop synchroniser on
// every sgn bit (adds 2 cycles to all latencies); without it sgn is assumed
// synchronous to clk and used directly.
module pred_mc
    import pred_pkg::*;
#(
    parameter int CHANNELS = PRED_CHANNELS_DEF,
    parameter int DELAY_W  = PRED_DELAY_W_DEF
) (
    input  logic    clk,
    input  logic    rst,
    pred_if.slave   bus
);

    logic [CHANNELS-1:0] sgn_q;
    logic [CHANNELS-1:0] sgn_pre_q;
    logic [CHANNELS-1:0] busy_q;

`ifdef PRED_SYNC_EN
    logic [CHANNELS-1:0] sgn_p0;
    logic [CHANNELS-1:0] sgn_p1;

    // Two-stage synchroniser for asynchronous channel inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sgn_p0 <= '0;
            sgn_p1 <= '0;
        end else begin
            sgn_p0 <= bus.sgn;
            sgn_p1 <= sgn_p0;
        end
    end

    assign sgn_q = sgn_p1;
`else
    assign sgn_q = bus.sgn;
`endif

    // One independent delay channel per input bit, sharing the delay settings.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        pred_chan #(
            .DELAY_W (DELAY_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .sgn        (sgn_q[g]),
            .shift_rise (bus.shift_rise),
            .shift_fall (bus.shift_fall),
            .mode       (bus.mode),
            .sgn_pre    (sgn_pre_q[g]),
            .busy       (busy_q[g])
        );
    end

    assign bus.sgn_pre = sgn_pre_q;
    assign bus.busy    = busy_q;

endmodule
